life_matrix_scanner: RTL and testbench

- Reader side of the 256-bit life map: consumes the map the generation engine writes and row-scans it onto a 16x16 LED matrix.
- Snapshots the map only at frame boundaries, so a generation update never tears a displayed frame.
- Drives one row at a time, with a blanking gap between rows to suppress ghosting.
- Sits between the generation engine's map register and the matrix row/column driver pins.

---
 rtl/life_pkg.sv | 19 +
 rtl/life_row_timer.sv | 27 ++
 rtl/life_matrix_scanner.sv | 169 ++++++++++++++++
 tb/tb_life_matrix_scanner.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared grid geometry, scan state encoding and cell indexing for the life map.
package life_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;
  localparam int CELLS  = GRID_W * GRID_H;

  typedef enum logic [1:0] {
    LOAD,
    DRIVE,
    BLANK
  } scan_state_t;

  // Bit position of cell (x, y) in the flat map: y*16 + x.
  function automatic logic [7:0] idx(input logic [3:0] x, input logic [3:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/life_row_timer.sv
// Loadable down-counter timing the DRIVE dwell and BLANK gap of each row.
module life_row_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // A loaded value of N-1 keeps done low for N-1 cycles, giving N cycles in the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/life_matrix_scanner.sv
// Tear-free row scanner for the 16x16 life map onto an LED matrix.
// Optional macro CURSOR_BLINK_EN adds a blinking edit cursor on the displayed map.
module life_matrix_scanner
  import life_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CELLS-1:0]  map,
  input  logic              map_update,
  input  logic [3:0]        cursor_x,
  input  logic [3:0]        cursor_y,
  output logic [GRID_H-1:0] row_sel,
  output logic [GRID_W-1:0] col_data,
  output logic              frame_done
);

  localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_t       state, next_state;
  logic [3:0]        row, next_row;
  logic [CELLS-1:0]  snapshot, snap_next;
  logic              pending;
  logic              timer_load, timer_done;
  logic [TW-1:0]     timer_value;
  logic              advance, frame_end;
  logic [GRID_H-1:0] row_sel_d;
  logic [GRID_W-1:0] col_data_d;

  life_row_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // The map is only sampled on LOAD, so a new generation never splits a frame.
  assign snap_next = (state == LOAD && pending) ? map : snapshot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      row      <= '0;
      snapshot <= '0;
      pending  <= 1'b1;
    end else begin
      state    <= next_state;
      row      <= next_row;
      snapshot <= snap_next;
      if (state == LOAD && pending) begin
        pending <= map_update;
      end else begin
        pending <= pending | map_update;
      end
    end
  end

  always_comb begin
    next_state  = state;
    next_row    = row;
    timer_load  = 1'b0;
    timer_value = DWELL_LAST;
    advance     = 1'b0;
    frame_end   = 1'b0;
    unique case (state)
      LOAD: begin
        next_state = DRIVE;
        next_row   = '0;
        timer_load = 1'b1;
      end
      DRIVE: begin
        if (timer_done) begin
          if (BLANK_CYCLES > 0) begin
            next_state  = BLANK;
            timer_load  = 1'b1;
            timer_value = BLANK_LAST;
          end else begin
            advance = 1'b1;
          end
        end
      end
      BLANK: begin
        advance = timer_done;
      end
      default: next_state = LOAD;
    endcase
    // Row 15 always returns through LOAD, which is where frame_done is shown.
    if (advance) begin
      if (row == 4'd15) begin
        next_state = LOAD;
        frame_end  = 1'b1;
      end else begin
        next_state  = DRIVE;
        next_row    = row + 4'd1;
        timer_load  = 1'b1;
        timer_value = DWELL_LAST;
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    cur_x, cur_y, cur_x_next, cur_y_next;

  assign cur_x_next = (state == LOAD) ? cursor_x : cur_x;
  assign cur_y_next = (state == LOAD) ? cursor_y : cur_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
    end else begin
      cur_x <= cur_x_next;
      cur_y <= cur_y_next;
      if (frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x, cursor_y, BLINK_FRAMES[0]};
`endif

  // Outputs are decoded from the upcoming state so the registers line up with it.
  always_comb begin
    row_sel_d  = '0;
    col_data_d = '0;
    if (next_state == DRIVE) begin
      row_sel_d[next_row] = 1'b1;
      col_data_d          = snap_next[idx(4'd0, next_row) +: GRID_W];
`ifdef CURSOR_BLINK_EN
      if (blink_phase && next_row == cur_y_next) begin
        col_data_d[cur_x_next] = ~col_data_d[cur_x_next];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      row_sel    <= row_sel_d;
      col_data   <= col_data_d;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_life_matrix_scanner.sv
// Self-checking bench for life_matrix_scanner against a frame-schedule reference model.
// Define CURSOR_BLINK_EN for both RTL and bench to exercise the cursor blink.
module tb_life_matrix_scanner;

  localparam int DW  = 4;
  localparam int BL  = 1;
  localparam int BF  = 2;
  localparam int SLOT = DW + BL;
  localparam int PER = 1 + 16 * SLOT;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] map;
  logic         map_update;
  logic [3:0]   cursor_x, cursor_y;
  logic [15:0]  row_sel, col_data;
  logic         frame_done;

  int checks = 0;
  int passes = 0;

  // Reference model: position within the frame plus the displayed generation.
  int           m_phase;
  logic [255:0] m_snap;
  bit           m_pend;
  bit           m_wrapped;
  int           m_frames;
  logic [3:0]   m_cx, m_cy;

  always #5 clk = ~clk;

  life_matrix_scanner #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .map        (map),
    .map_update (map_update),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_phase   = 0;
      m_snap    = '0;
      m_pend    = 1'b1;
      m_wrapped = 1'b0;
      m_frames  = 0;
      m_cx      = '0;
      m_cy      = '0;
    end else begin
      if (m_phase == 0) begin
        if (m_pend) begin
          m_snap = map;
          m_pend = map_update;
        end else begin
          m_pend = map_update;
        end
        m_cx = cursor_x;
        m_cy = cursor_y;
      end else begin
        m_pend = m_pend | map_update;
      end
      m_phase   = (m_phase + 1) % PER;
      m_wrapped = (m_phase == 0);
      if (m_phase == 0) m_frames++;
    end
    @(negedge clk);
  endtask

  function automatic int exp_row();
    int k;
    if (m_phase == 0) return -1;
    k = m_phase - 1;
    if ((k % SLOT) < DW) return k / SLOT;
    return -1;
  endfunction

  function automatic logic [15:0] exp_row_sel();
    int r;
    r = exp_row();
    if (r < 0) return 16'h0000;
    return 16'h0001 << r;
  endfunction

  function automatic logic [15:0] exp_col();
    int r;
    logic [15:0] c;
    r = exp_row();
    if (r < 0) return 16'h0000;
    c = m_snap[r*16 +: 16];
`ifdef CURSOR_BLINK_EN
    if (((m_frames / BF) % 2) == 1 && r == int'(m_cy)) c[m_cx] = ~c[m_cx];
`endif
    return c;
  endfunction

  function automatic logic exp_fd();
    return (m_phase == 0) && m_wrapped;
  endfunction

  function automatic logic [255:0] rand_map();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < PER && m_phase != 1 + 5 * SLOT + 2; i++) tick();
    checks++;
    if (row_sel !== 16'h0020) $display("[TB] FAIL reset_pre_row5: row_sel=%h required 0020", row_sel);
    else passes++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({row_sel, col_data, frame_done} !== 33'd0)
        $display("[TB] FAIL reset_outputs: row_sel=%h col=%h fd=%b required 0/0/0", row_sel, col_data, frame_done);
      else passes++;
    end
    rst = 1'b0;
    for (int i = 0; i < DW; i++) begin
      tick();
      checks++;
      if (row_sel !== 16'h0001 || frame_done !== 1'b0)
        $display("[TB] FAIL reset_first_row: row_sel=%h fd=%b required 0001/0", row_sel, frame_done);
      else passes++;
    end
    tick();
    checks++;
    if (row_sel !== 16'h0000) $display("[TB] FAIL reset_first_blank: row_sel=%h required 0000", row_sel);
    else passes++;
  endtask

  task automatic test_single_cell();
    int hits, stray, fds, last_fd;
    logic [255:0] m;
    m = '0;
    m[17] = 1'b1;
    map = m;
    map_update = 1'b1;
    tick();
    map_update = 1'b0;
    for (int i = 0; i < PER && m_phase != 0; i++) tick();
    hits = 0; stray = 0; fds = 0; last_fd = -1;
    for (int i = 0; i < 2 * PER; i++) begin
      tick();
      checks++;
      if ({row_sel, col_data, frame_done} !== {exp_row_sel(), exp_col(), exp_fd()})
        $display("[TB] FAIL single_cell_model phase=%0d: got %h/%h/%b required %h/%h/%b",
                 m_phase, row_sel, col_data, frame_done, exp_row_sel(), exp_col(), exp_fd());
      else passes++;
      if (row_sel == 16'h0002 && col_data == 16'h0002) hits++;
      else if (col_data != 16'h0000) stray++;
      if (frame_done) begin
        if (last_fd >= 0) begin
          checks++;
          if (i - last_fd !== PER) $display("[TB] FAIL frame_period: got %0d required %0d", i - last_fd, PER);
          else passes++;
        end
        last_fd = i;
        fds++;
      end
    end
    checks++;
    if (hits !== 2 * DW || stray !== 0 || fds !== 2)
      $display("[TB] FAIL single_cell_counts: hits=%0d stray=%0d fds=%0d required %0d/0/2", hits, stray, fds, 2 * DW);
    else passes++;
  endtask

  task automatic test_tear_free();
    logic [255:0] old_map, new_map;
    int r;
    for (int i = 0; i < PER && m_phase != 1 + 7 * SLOT + 1; i++) tick();
    old_map = m_snap;
    new_map = rand_map();
    map = new_map;
    map_update = 1'b1;
    tick();
    map_update = 1'b0;
    while (m_phase != 0) begin
      tick();
      r = exp_row();
      if (r >= 8) begin
        checks++;
        if (col_data !== old_map[r*16 +: 16])
          $display("[TB] FAIL tear_old_row%0d: col=%h required %h", r, col_data, old_map[r*16 +: 16]);
        else passes++;
      end
    end
    for (int i = 0; i < PER; i++) begin
      tick();
      checks++;
      if ({row_sel, col_data, frame_done} !== {exp_row_sel(), exp_col(), exp_fd()})
        $display("[TB] FAIL tear_model phase=%0d: got %h/%h/%b required %h/%h/%b",
                 m_phase, row_sel, col_data, frame_done, exp_row_sel(), exp_col(), exp_fd());
      else passes++;
      if (m_phase == 1) begin
        checks++;
        if (col_data !== new_map[15:0]) $display("[TB] FAIL tear_new_row0: col=%h required %h", col_data, new_map[15:0]);
        else passes++;
      end
    end
  endtask

  task automatic test_load_strobe();
    logic [255:0] old_map, new_map;
    for (int i = 0; i < PER && m_phase != 0; i++) tick();
    old_map = m_snap;
    new_map = rand_map();
    map = new_map;
    map_update = 1'b1;
    tick();
    map_update = 1'b0;
    checks++;
    if (col_data !== old_map[15:0]) $display("[TB] FAIL load_strobe_old: col=%h required %h", col_data, old_map[15:0]);
    else passes++;
    for (int i = 0; i < PER; i++) begin
      tick();
      checks++;
      if ({row_sel, col_data, frame_done} !== {exp_row_sel(), exp_col(), exp_fd()})
        $display("[TB] FAIL load_strobe_model phase=%0d: got %h/%h/%b required %h/%h/%b",
                 m_phase, row_sel, col_data, frame_done, exp_row_sel(), exp_col(), exp_fd());
      else passes++;
    end
    checks++;
    if (col_data !== new_map[15:0]) $display("[TB] FAIL load_strobe_new: col=%h required %h", col_data, new_map[15:0]);
    else passes++;
  endtask

  task automatic test_blanking();
    logic [15:0] last, want;
    int gap, want_gap;
    last = 16'h0000;
    gap = 0;
    for (int i = 0; i < 2 * PER + 2; i++) begin
      tick();
      checks++;
      if ((row_sel & (row_sel - 16'h0001)) !== 16'h0000) $display("[TB] FAIL onehot: row_sel=%h", row_sel);
      else passes++;
      if (row_sel == 16'h0000) begin
        gap++;
        checks++;
        if (col_data !== 16'h0000) $display("[TB] FAIL blank_col: col=%h required 0000", col_data);
        else passes++;
      end else if (row_sel != last) begin
        if (last != 16'h0000) begin
          want     = (last == 16'h8000) ? 16'h0001 : (last << 1);
          want_gap = (last == 16'h8000) ? BL + 1 : BL;
          checks++;
          if (row_sel !== want || gap !== want_gap)
            $display("[TB] FAIL row_order: row_sel=%h gap=%0d required %h gap=%0d", row_sel, gap, want, want_gap);
          else passes++;
        end
        last = row_sel;
        gap = 0;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * PER; i++) begin
      map_update = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        map = rand_map();
        map_update = 1'b1;
      end else if ($urandom_range(0, 19) == 0) begin
        map = rand_map();
      end
      tick();
      checks++;
      if ({row_sel, col_data, frame_done} !== {exp_row_sel(), exp_col(), exp_fd()})
        $display("[TB] FAIL random_model phase=%0d: got %h/%h/%b required %h/%h/%b",
                 m_phase, row_sel, col_data, frame_done, exp_row_sel(), exp_col(), exp_fd());
      else passes++;
    end
    map_update = 1'b0;
  endtask

`ifdef CURSOR_BLINK_EN
  task automatic test_cursor();
    logic [15:0] want;
    map = '0;
    map_update = 1'b0;
    cursor_x = 4'd3;
    cursor_y = 4'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6 * PER; i++) begin
      tick();
      if (exp_row() == 2) begin
        want = (m_frames == 2 || m_frames == 3) ? 16'h0008 : 16'h0000;
        checks++;
        if (col_data !== want) $display("[TB] FAIL cursor_frame%0d: col=%h required %h", m_frames, col_data, want);
        else passes++;
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    map = '0;
    map_update = 1'b0;
    cursor_x = 4'd0;
    cursor_y = 4'd0;
    m_phase = 0; m_snap = '0; m_pend = 1'b1; m_wrapped = 1'b0; m_frames = 0; m_cx = '0; m_cy = '0;
    test_reset();
    test_single_cell();
    test_tear_free();
    test_load_strobe();
    test_blanking();
    test_random();
`ifdef CURSOR_BLINK_EN
    test_cursor();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
